// File: rtl/gbe_udp_pktgen_if.sv
// Application TX bus between the UDP packet generator and the GbE core.
// master: generator side (drives data/dvld/eof/destip/destport, sees afull/overflow)
// slave : core side (sinks bytes, returns afull/overflow)
interface gbe_udp_pktgen_if;
    logic [7:0]  app_tx_data;
    logic        app_tx_dvld;
    logic        app_tx_eof;
    logic [31:0] app_tx_destip;
    logic [15:0] app_tx_destport;
    logic        app_tx_afull;
    logic        app_tx_overflow;

    modport master (
        output app_tx_data, app_tx_dvld, app_tx_eof, app_tx_destip, app_tx_destport,
        input  app_tx_afull, app_tx_overflow
    );

    modport slave (
        input  app_tx_data, app_tx_dvld, app_tx_eof, app_tx_destip, app_tx_destport,
        output app_tx_afull, app_tx_overflow
    );
endinterface

// File: rtl/gbe_udp_pktgen.sv
// UDP test packet generator for the GbE core application TX port.
// Emits numbered packets (4-byte big-endian sequence header + index payload)
// of programmable length, destination and inter-packet gap, honouring afull.
// Ports:
//   app_clk, app_rst_n        clock, async active-low reset
//   cfg_*                     run control and packet parameters
//   tx (master)               app_tx_* bus to the core
//   busy, done                generator status
//   stat_pkts, stat_overflow  packet count and saturating overflow-cycle count
module gbe_udp_pktgen #(
    parameter int unsigned MIN_LEN = 4
) (
    input  logic                 app_clk,
    input  logic                 app_rst_n,
    input  logic                 cfg_enable,
    input  logic [31:0]          cfg_destip,
    input  logic [15:0]          cfg_destport,
    input  logic [10:0]          cfg_len,
    input  logic [15:0]          cfg_gap,
    input  logic [31:0]          cfg_count,
    gbe_udp_pktgen_if.master     tx,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          stat_pkts,
    output logic [15:0]          stat_overflow
);

    localparam int unsigned LEN_W = 11;
    localparam int unsigned GAP_W = 16;
    localparam int unsigned SEQ_W = 32;
    localparam int unsigned OVF_W = 16;
    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
    localparam logic [OVF_W-1:0] OVF_MAX   = {OVF_W{1'b1}};

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_GAP, S_DONE} state_e;

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [31:0]        destip_q, destip_d;
    logic [15:0]        destport_q, destport_d;
    logic [7:0]         data_q, data_d;
    logic               dvld_q, dvld_d;
    logic               eof_q, eof_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        pkts_q, pkts_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;

    logic               start_pkt;
    logic               clr_stats;
    logic [7:0]         hdr_byte;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        en_d       = cfg_enable;
        seq_d      = seq_q;
        idx_d      = idx_q;
        len_d      = len_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        destip_d   = destip_q;
        destport_d = destport_q;
        data_d     = data_q;
        dvld_d     = 1'b0;
        eof_d      = 1'b0;
        pkts_d     = pkts_q;
        ovf_d      = ovf_q;
        start_pkt  = 1'b0;
        clr_stats  = 1'b0;

        unique case (idx_q[1:0])
            2'd0:    hdr_byte = seq_q[31:24];
            2'd1:    hdr_byte = seq_q[23:16];
            2'd2:    hdr_byte = seq_q[15:8];
            default: hdr_byte = seq_q[7:0];
        endcase

        case (state_q)
            // Registered enable gives the extra start cycle; a level held
            // high after a stop restarts the same way as a fresh edge.
            S_IDLE: begin
                if (en_q) begin
                    start_pkt = 1'b1;
                    clr_stats = 1'b1;
                end
            end
            S_HDR, S_PAY: begin
                if (!tx.app_tx_afull) begin
                    dvld_d = 1'b1;
                    data_d = (state_q == S_HDR) ? hdr_byte : idx_q[7:0];
                    idx_d  = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        eof_d     = 1'b1;
                        seq_d     = seq_q + SEQ_W'(1);
                        pkts_d    = pkts_q + 32'd1;
                        gap_cnt_d = gap_q;
                        state_d   = S_GAP;
                    end else if (idx_q == LEN_W'(3)) begin
                        state_d = S_PAY;
                    end
                end
            end
            // Zero count doubles as the packet-boundary decision cycle.
            S_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else if ((cfg_count != 32'd0) && (pkts_q == cfg_count)) begin
                    state_d = S_DONE;
                end else if (!cfg_enable) begin
                    state_d = S_IDLE;
                end else begin
                    start_pkt = 1'b1;
                end
            end
            S_DONE: begin
                if (!cfg_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clr_stats) begin
            seq_d  = '0;
            pkts_d = '0;
        end

        if (start_pkt) begin
            state_d    = S_HDR;
            idx_d      = '0;
            len_d      = (cfg_len < MIN_LEN_L) ? MIN_LEN_L : cfg_len;
            gap_d      = cfg_gap;
            destip_d   = cfg_destip;
            destport_d = cfg_destport;
        end

        if (clr_stats) begin
            ovf_d = '0;
        end else if (tx.app_tx_overflow && (ovf_q != OVF_MAX)) begin
            ovf_d = ovf_q + OVF_W'(1);
        end

        busy_d = (state_d == S_HDR) || (state_d == S_PAY) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            seq_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            destip_q   <= '0;
            destport_q <= '0;
            data_q     <= '0;
            dvld_q     <= 1'b0;
            eof_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pkts_q     <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            seq_q      <= seq_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            destip_q   <= destip_d;
            destport_q <= destport_d;
            data_q     <= data_d;
            dvld_q     <= dvld_d;
            eof_q      <= eof_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pkts_q     <= pkts_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx.app_tx_data     = data_q;
    assign tx.app_tx_dvld     = dvld_q;
    assign tx.app_tx_eof      = eof_q;
    assign tx.app_tx_destip   = destip_q;
    assign tx.app_tx_destport = destport_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign stat_pkts          = pkts_q;
    assign stat_overflow      = ovf_q;

endmodule
